// File: rtl/rv32i_dmem_bus_pkg.sv
// Shared register map and bit positions for the RV32I data-side memory responder.
package rv32i_dmem_pkg;

    localparam logic [7:0] OFS_LED    = 8'h00;
    localparam logic [7:0] OFS_TCNT   = 8'h04;
    localparam logic [7:0] OFS_TCMP   = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_CTRL   = 8'h10;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int CTRL_W          = 3;

    localparam int STAT_MATCH = 0;

endpackage

// File: rtl/rv32i_dmem_bus_if.sv
// CPU data port: write strobe, byte address, write data and combinational read data.
interface rv32i_dmem_bus_if;
    import rv32i_dmem_pkg::*;

    logic        Memwrite;
    logic [31:0] Memaddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;

    modport master (output Memwrite, output Memaddr, output MemWdata, input MemRdata);
    modport slave  (input Memwrite, input Memaddr, input MemWdata, output MemRdata);

endinterface

// File: rtl/rv32i_dmem_bus_timer.sv
// Free-running 32-bit timer with compare, sticky MATCH flag, control bits and registered irq.
module dmem_timer
    import rv32i_dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_tcnt,
    input  logic              wr_tcmp,
    input  logic              wr_status,
    input  logic              wr_ctrl,
    input  logic [31:0]       wdata,
    output logic [31:0]       tcnt,
    output logic [31:0]       tcmp,
    output logic              match,
    output logic [CTRL_W-1:0] ctrl,
    output logic              irq
);

    logic [31:0]       tcnt_q, tcnt_d;
    logic [31:0]       tcmp_q, tcmp_d;
    logic              match_q, match_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              irq_q, irq_d;
    logic              hit;

    always_comb begin
        tcnt_d  = tcnt_q;
        tcmp_d  = tcmp_q;
        match_d = match_q;
        ctrl_d  = ctrl_q;
        hit     = ctrl_q[CTRL_EN] && (tcnt_q == tcmp_q);

        if (ctrl_q[CTRL_EN])
            tcnt_d = (hit && ctrl_q[CTRL_AUTORELOAD]) ? 32'h0 : tcnt_q + 32'h1;
        // CPU load of the counter beats the increment/reload in the same cycle
        if (wr_tcnt)
            tcnt_d = wdata;
        if (wr_tcmp)
            tcmp_d = wdata;

        // Set beats W1C clear when both happen together
        if (wr_status && wdata[STAT_MATCH])
            match_d = 1'b0;
        if (hit)
            match_d = 1'b1;

        if (wr_ctrl)
            ctrl_d = wdata[CTRL_W-1:0];

        irq_d = match_q & ctrl_q[CTRL_IRQEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q  <= '0;
            tcmp_q  <= '0;
            match_q <= 1'b0;
            ctrl_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            match_q <= match_d;
            ctrl_q  <= ctrl_d;
            irq_q   <= irq_d;
        end
    end

    assign tcnt  = tcnt_q;
    assign tcmp  = tcmp_q;
    assign match = match_q;
    assign ctrl  = ctrl_q;
    assign irq   = irq_q;

endmodule

// File: rtl/rv32i_dmem_bus.sv
// Data-side responder: decodes CPU accesses to a word RAM or to the LED/timer register bank.
module rv32i_dmem_bus
    import rv32i_dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          LED_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    rv32i_dmem_bus_if.slave  bus,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]       mem_q [RAM_WORDS];
    logic [31:0]       led_q, led_d;
    logic [31:0]       ram_off;
    logic [AW-1:0]     ram_idx;
    logic              ram_hit, mmio_hit, mmio_wr;
    logic [7:0]        mmio_ofs;
    logic [31:0]       rdata;
    logic [31:0]       tcnt, tcmp;
    logic              match;
    logic [CTRL_W-1:0] ctrl;

    // Unsigned offset from the window base also rejects addresses below the base
    assign ram_off  = bus.Memaddr - RAM_BASE;
    assign ram_hit  = ram_off < RAM_BYTES;
    assign ram_idx  = ram_off[AW+1:2];
    assign mmio_hit = bus.Memaddr[31:8] == MMIO_BASE[31:8];
    assign mmio_ofs = {bus.Memaddr[7:2], 2'b00};
    assign mmio_wr  = bus.Memwrite && mmio_hit;

    always_comb begin
        led_d = led_q;
        if (mmio_wr && mmio_ofs == OFS_LED)
            led_d = bus.MemWdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led_q <= '0;
        else
            led_q <= led_d;
    end

    always_ff @(posedge clk) begin
        if (bus.Memwrite && ram_hit)
            mem_q[ram_idx] <= bus.MemWdata;
    end

    dmem_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_tcnt   (mmio_wr && mmio_ofs == OFS_TCNT),
        .wr_tcmp   (mmio_wr && mmio_ofs == OFS_TCMP),
        .wr_status (mmio_wr && mmio_ofs == OFS_STATUS),
        .wr_ctrl   (mmio_wr && mmio_ofs == OFS_CTRL),
        .wdata     (bus.MemWdata),
        .tcnt      (tcnt),
        .tcmp      (tcmp),
        .match     (match),
        .ctrl      (ctrl),
        .irq       (irq)
    );

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = mem_q[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_ofs)
                OFS_LED:    rdata = led_q;
                OFS_TCNT:   rdata = tcnt;
                OFS_TCMP:   rdata = tcmp;
                OFS_STATUS: rdata[STAT_MATCH] = match;
                OFS_CTRL:   rdata[CTRL_W-1:0] = ctrl;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.MemRdata = rdata;
    assign led          = led_q[LED_W-1:0];

endmodule

// File: tb/tb_rv32i_dmem_bus.sv
// Bench for rv32i_dmem_bus: directed vector table, timer corner sequences, randomized model check.
module tb_rv32i_dmem_bus;

    localparam logic [31:0] MB     = 32'hFFFF_0000;
    localparam logic [31:0] A_LED  = MB + 32'h00;
    localparam logic [31:0] A_TCNT = MB + 32'h04;
    localparam logic [31:0] A_TCMP = MB + 32'h08;
    localparam logic [31:0] A_STAT = MB + 32'h0C;
    localparam logic [31:0] A_CTRL = MB + 32'h10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led;
    logic       irq;

    rv32i_dmem_bus_if bus ();

    rv32i_dmem_bus #(
        .RAM_WORDS (1024),
        .RAM_BASE  (32'h0000_2000),
        .MMIO_BASE (32'hFFFF_0000),
        .LED_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vt[$];

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_led, m_tcnt, m_tcmp;
    logic        m_match, m_irq;
    logic [2:0]  m_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Memwrite = 1'b1;
        bus.Memaddr  = a;
        bus.MemWdata = d;
        tick();
        bus.Memwrite = 1'b0;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] a, input logic [31:0] e);
        bus.Memwrite = 1'b0;
        bus.Memaddr  = a;
        #1;
        check(name, bus.MemRdata, e);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_led = '0; m_tcnt = '0; m_tcmp = '0; m_match = 1'b0; m_irq = 1'b0; m_ctrl = '0;
    endtask

    task automatic model_read(input logic [31:0] a, output logic ok, output logic [31:0] d);
        int w;
        ok = 1'b1;
        d  = 32'h0;
        if (a >= 32'h0000_2000 && a < 32'h0000_3000) begin
            w  = int'((a - 32'h0000_2000) / 4);
            ok = m_ram.exists(w);
            if (ok) d = m_ram[w];
        end else if (a[31:8] == 24'hFFFF00) begin
            case (a[7:0] & 8'hFC)
                8'h00:   d = m_led;
                8'h04:   d = m_tcnt;
                8'h08:   d = m_tcmp;
                8'h0C:   d = {31'h0, m_match};
                8'h10:   d = {29'h0, m_ctrl};
                default: d = 32'h0;
            endcase
        end
    endtask

    // One bus cycle: check outputs against the model, then advance the model across the edge
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic        ok;
        logic [31:0] exp;
        logic [31:0] n_led, n_tcnt, n_tcmp;
        logic        n_match, n_irq, running, fire;
        logic [2:0]  n_ctrl;
        logic [7:0]  ofs;
        bus.Memwrite = we;
        bus.Memaddr  = a;
        bus.MemWdata = d;
        #1;
        model_read(a, ok, exp);
        if (ok) check("rnd_rdata", bus.MemRdata, exp);
        check("rnd_led", {24'h0, led}, {24'h0, m_led[7:0]});
        check("rnd_irq", {31'h0, irq}, {31'h0, m_irq});

        running = m_ctrl[0];
        fire    = running && (m_tcnt == m_tcmp);
        n_led = m_led; n_tcmp = m_tcmp; n_ctrl = m_ctrl;
        n_irq = m_match && m_ctrl[2];
        n_tcnt = m_tcnt;
        if (running) n_tcnt = (fire && m_ctrl[1]) ? 32'h0 : m_tcnt + 1;
        n_match = m_match;
        ofs = a[7:0] & 8'hFC;
        if (we && a[31:8] == 24'hFFFF00 && ofs == 8'h0C && d[0]) n_match = 1'b0;
        if (fire) n_match = 1'b1;
        if (we) begin
            if (a >= 32'h0000_2000 && a < 32'h0000_3000)
                m_ram[int'((a - 32'h0000_2000) / 4)] = d;
            else if (a[31:8] == 24'hFFFF00) begin
                case (ofs)
                    8'h00: n_led  = d;
                    8'h04: n_tcnt = d;
                    8'h08: n_tcmp = d;
                    8'h10: n_ctrl = d[2:0];
                    default: ;
                endcase
            end
        end
        tick();
        bus.Memwrite = 1'b0;
        m_led = n_led; m_tcnt = n_tcnt; m_tcmp = n_tcmp;
        m_match = n_match; m_irq = n_irq; m_ctrl = n_ctrl;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [7:0]  ofs;
        logic        we;
        int          k;

        reset        = 1'b1;
        bus.Memwrite = 1'b0;
        bus.Memaddr  = 32'h0;
        bus.MemWdata = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        expect_rd("rst_tcnt", A_TCNT, 32'h0);
        expect_rd("rst_ctrl", A_CTRL, 32'h0);
        reset = 1'b0;
        tick();

        vt.push_back('{1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 1'b0, 32'h0,         8'h00});
        vt.push_back('{1'b0, 32'h0000_2004, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00});
        vt.push_back('{1'b0, 32'h0000_2007, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00});
        vt.push_back('{1'b0, 32'h0000_1FFC, 32'h0,         1'b1, 32'h0,         8'h00});
        vt.push_back('{1'b1, A_LED,         32'h0000_00A5, 1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 8'hA5});
        vt.push_back('{1'b0, MB + 32'h14,   32'h0,         1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b1, MB + 32'h14,   32'hFFFF_FFFF, 1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b0, MB + 32'h14,   32'h0,         1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 8'hA5});
        vt.push_back('{1'b1, 32'h0000_2FFC, 32'h1234_5678, 1'b0, 32'h0,         8'hA5});
        vt.push_back('{1'b0, 32'h0000_2FFC, 32'h0,         1'b1, 32'h1234_5678, 8'hA5});
        vt.push_back('{1'b1, 32'h0000_3000, 32'h0000_0055, 1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b0, 32'h0000_3000, 32'h0,         1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b1, 32'hFFFF_0100, 32'h0000_00FF, 1'b1, 32'h0,         8'hA5});
        vt.push_back('{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 8'hA5});
        vt.push_back('{1'b1, 32'h0000_2004, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 8'hA5});
        vt.push_back('{1'b0, 32'h0000_2004, 32'h0,         1'b1, 32'h0BAD_F00D, 8'hA5});
        vt.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0,         8'hA5});

        foreach (vt[i]) begin
            bus.Memwrite = vt[i].we;
            bus.Memaddr  = vt[i].addr;
            bus.MemWdata = vt[i].wdata;
            #1;
            if (vt[i].chk) check($sformatf("vec%0d_rd", i), bus.MemRdata, vt[i].exp_rd);
            tick();
            check($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vt[i].exp_led});
        end
        bus.Memwrite = 1'b0;

        // Autoreload: TCMP=5 gives a 6-cycle period
        do_reset();
        wr(A_TCMP, 32'd5);
        wr(A_CTRL, 32'd3);
        wr(A_TCNT, 32'd0);
        for (int i = 0; i <= 5; i++) begin
            expect_rd($sformatf("ar_tcnt%0d", i), A_TCNT, 32'(i));
            expect_rd($sformatf("ar_stat%0d", i), A_STAT, 32'h0);
            tick();
        end
        expect_rd("ar_wrap_tcnt", A_TCNT, 32'h0);
        expect_rd("ar_match", A_STAT, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_rd($sformatf("ar2_tcnt%0d", i), A_TCNT, 32'(i));
        end
        tick();
        expect_rd("ar_period", A_TCNT, 32'h0);

        // IRQ timing without reload, then W1C
        do_reset();
        wr(A_TCMP, 32'd3);
        wr(A_CTRL, 32'd5);
        wr(A_TCNT, 32'd0);
        tick(); tick(); tick();
        expect_rd("irq_tcnt3", A_TCNT, 32'd3);
        check("irq_low_at3", {31'h0, irq}, 32'h0);
        tick();
        expect_rd("irq_tcnt4", A_TCNT, 32'd4);
        expect_rd("irq_match", A_STAT, 32'h1);
        check("irq_low_at4", {31'h0, irq}, 32'h0);
        tick();
        check("irq_high", {31'h0, irq}, 32'h1);
        wr(A_STAT, 32'h1);
        expect_rd("w1c_clear", A_STAT, 32'h0);
        check("irq_lag", {31'h0, irq}, 32'h1);
        tick();
        check("irq_drop", {31'h0, irq}, 32'h0);

        // Collisions: W1C vs match, TCNT write vs increment
        do_reset();
        wr(A_TCMP, 32'd3);
        wr(A_CTRL, 32'd1);
        wr(A_TCNT, 32'd0);
        tick(); tick(); tick();
        wr(A_STAT, 32'h1);
        expect_rd("set_wins", A_STAT, 32'h1);
        wr(A_TCNT, 32'd100);
        expect_rd("tcnt_load", A_TCNT, 32'd100);
        tick();
        expect_rd("tcnt_inc", A_TCNT, 32'd101);

        // Wrap without match
        wr(A_STAT, 32'h1);
        expect_rd("w1c2", A_STAT, 32'h0);
        wr(A_TCNT, 32'hFFFF_FFFF);
        expect_rd("wrap_pre", A_TCNT, 32'hFFFF_FFFF);
        tick();
        expect_rd("wrap_zero", A_TCNT, 32'h0);
        expect_rd("wrap_nomatch", A_STAT, 32'h0);

        // EN=0 holds and never matches; a new TCMP compares from the next cycle
        wr(A_CTRL, 32'd0);
        wr(A_TCNT, 32'd7);
        wr(A_TCMP, 32'd7);
        tick(); tick();
        expect_rd("hold_tcnt", A_TCNT, 32'd7);
        expect_rd("hold_nomatch", A_STAT, 32'h0);
        wr(A_TCMP, 32'd50);
        wr(A_CTRL, 32'd1);
        wr(A_TCMP, 32'd7);
        expect_rd("tcmp_late_tcnt", A_TCNT, 32'd8);
        expect_rd("tcmp_late_stat", A_STAT, 32'h0);

        // Asynchronous reset mid-count with a write in flight
        do_reset();
        wr(A_LED, 32'h0000_00A5);
        wr(A_TCMP, 32'd2);
        wr(A_CTRL, 32'd7);
        wr(A_TCNT, 32'd0);
        k = 0;
        while (irq !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        check("arst_pre_irq", {31'h0, irq}, 32'h1);
        bus.Memwrite = 1'b1;
        bus.Memaddr  = A_LED;
        bus.MemWdata = 32'h0000_00FF;
        #2;
        reset = 1'b1;
        #1;
        check("arst_led", {24'h0, led}, 32'h0);
        check("arst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("arst_led_hold", {24'h0, led}, 32'h0);
        expect_rd("arst_tcnt", A_TCNT, 32'h0);
        expect_rd("arst_tcmp", A_TCMP, 32'h0);
        expect_rd("arst_ctrl", A_CTRL, 32'h0);
        reset = 1'b0;
        tick();
        expect_rd("arst_led_reg", A_LED, 32'h0);
        expect_rd("arst_stat", A_STAT, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        m_ram.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h0000_2000 + 32'(i * 4), $urandom);
        for (int n = 0; n < 3000; n++) begin
            k  = $urandom_range(0, 9);
            we = ($urandom_range(0, 99) < 35);
            d  = $urandom;
            if (k <= 3) begin
                a = 32'h0000_2000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end else if (k <= 7) begin
                case ($urandom_range(0, 5))
                    0: ofs = 8'h00;
                    1: ofs = 8'h04;
                    2: ofs = 8'h08;
                    3: ofs = 8'h0C;
                    4: ofs = 8'h10;
                    default: ofs = 8'($urandom_range(0, 255));
                endcase
                a = MB | {24'h0, ofs} | 32'($urandom_range(0, 3));
                if ((ofs & 8'hFC) == 8'h04 || (ofs & 8'hFC) == 8'h08)
                    if ($urandom_range(0, 9) < 8) d = 32'($urandom_range(0, 15));
                if ((ofs & 8'hFC) == 8'h10 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            end else begin
                case ($urandom_range(0, 4))
                    0: a = 32'h0000_1FFC;
                    1: a = 32'h0000_3000;
                    2: a = 32'hFFFF_0100;
                    3: a = 32'hFFFE_FFFC;
                    default: a = $urandom;
                endcase
            end
            cycle(we, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_bus.md
# rv32i_dmem_bus

Data-side memory responder for the single-cycle RV32I CPU: it terminates the CPU's `Memwrite`/`Memaddr`/`MemWdata`/`MemRdata` data port. The block decodes each access to a word-addressed data RAM or to a small memory-mapped register bank: an LED output register and a 32-bit timer with compare, sticky match flag and interrupt. Instruction fetch is served elsewhere and is not handled here.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words (power of two).
- `RAM_BASE`, 32'h0000_2000: byte base address of the RAM window; size is RAM_WORDS*4.
- `MMIO_BASE`, 32'hFFFF_0000: byte base address of the 256-byte register window.
- `LED_W`, 8: width of the LED output.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `Memwrite`  in  1: write strobe from CPU, valid for the whole cycle.
- `Memaddr`  in  32: byte address (CPU ALU output).
- `MemWdata`  in  32: write data (CPU rs2).
- `MemRdata`  out  32: read data, combinational from `Memaddr`.
- `led`  out  LED_W: the low LED_W bits of the LED register.
- `irq`  out  1: timer interrupt, registered.

## Operation
- Decode:
  - RAM hit when `Memaddr` lies within [RAM_BASE, RAM_BASE+RAM_WORDS*4).
  - MMIO hit when `Memaddr[31:8]==MMIO_BASE[31:8]`.
  - Otherwise unmapped.
- `Memaddr[1:0]` is ignored; all accesses are full words, with no byte enables.
- RAM: `MemRdata = ram[word index]`. A write updates the word at the clock edge. RAM contents are not reset.
- MMIO offsets (`Memaddr[7:0]`):
  - 0x00 LED: R/W, 32 bits stored.
  - 0x04 TCNT: R/W. A write loads the counter.
  - 0x08 TCMP: R/W.
  - 0x0C STATUS: bit0 MATCH, sticky. Writing 1 to bit0 clears it (W1C); other bits read 0.
  - 0x10 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0 and ignore writes.
- Any other MMIO offset, and any unmapped address: read returns 32'h0 and writes are dropped.
- Timer, evaluated each cycle with EN=1:
  - If TCNT==TCMP, MATCH is set. TCNT then goes to 0 if AUTORELOAD=1, otherwise to TCNT+1.
  - If TCNT!=TCMP, TCNT goes to TCNT+1, wrapping from 32'hFFFF_FFFF to 0 without setting MATCH.
  - With EN=0 the counter holds and no match is detected.
- `irq` is registered as MATCH & IRQEN, i.e. it reflects those register values with one cycle of lag.
- Simultaneous events:
  - A CPU write to TCNT overrides the increment or reload in that cycle.
  - A match in the same cycle as a W1C of MATCH leaves MATCH set (set wins).
  - A write to TCMP takes effect for compare from the next cycle.

## Timing
- Reads have zero latency: `MemRdata` is purely combinational from `Memaddr` and current state, as the single-cycle CPU requires.
- Writes commit at the rising edge where `Memwrite`=1. Reading the same address in that cycle returns the old value; the new value is visible from the next cycle.
- Reset (asynchronous, any time, including mid-count or with `Memwrite` high):
  - LED, TCNT, TCMP, STATUS and CTRL go to 0.
  - `led`=0 and `irq`=0 immediately.
  - RAM is not reset.
- Once reset deasserts, state first updates at the next rising edge.
- Timing of MATCH and `irq`:
  - MATCH becomes visible the cycle after TCNT==TCMP is observed.
  - `irq` rises one cycle after MATCH is seen set with IRQEN=1.

## Structure
- Package `rv32i_dmem_pkg` holds:
  - register offsets (`OFS_LED`, `OFS_TCNT`, `OFS_TCMP`, `OFS_STATUS`, `OFS_CTRL`);
  - CTRL bit indices (`CTRL_EN`, `CTRL_AUTORELOAD`, `CTRL_IRQEN`);
  - the STATUS bit index `STAT_MATCH`.
- Sub-module `dmem_timer` holds:
  - TCNT, TCMP, MATCH, CTRL and `irq`;
  - inputs: decoded write strobes per register plus `MemWdata`;
  - outputs: register values for the read mux.
- The top level holds the RAM array, address decode, LED register and the read mux.

## Test plan
- Write 32'hDEADBEEF to 0x0000_2004, read back the next cycle -> 32'hDEADBEEF. A read of 0x0000_2007 also returns 32'hDEADBEEF. A read of 0x0000_1FFC returns 0.
- Write 32'h0000_00A5 to 0xFFFF_0000 -> `led`=8'hA5 after the edge. A read of offset 0x14 returns 0. A write to offset 0x14 changes nothing.
- Sequence: TCMP=5, then CTRL=3'b011, then TCNT=0 -> counts 0..5. MATCH=1 one cycle after TCNT=5, TCNT returns to 0, and the period is 6 cycles.
- CTRL=3'b101 (IRQEN, no reload) with TCMP=3:
  - `irq` asserts two cycles after TCNT==3, and TCNT continues to 4.
  - W1C to STATUS -> MATCH=0, and `irq` drops the following cycle.
- Collision cases:
  - W1C of STATUS in the same cycle as a match -> MATCH stays 1.
  - A write of TCNT=100 in the same cycle as an increment -> TCNT=100.
- Assert `reset` mid-count with `Memwrite`=1 -> all registers, `led` and `irq` go to 0 asynchronously. The write is not committed to registers.
